// File: rtl/trap_ctrl_pkg.sv
// trap_ctrl_pkg: shared types and constants for the machine-mode trap
// controller.
//   trap_state_t  - trap sequencer states
//   trap_kind_t   - kind of the accepted source (exception / interrupt / MRET)
//   exc_pc_mux_t  - fetch redirect source select
//   EXC_CAUSE_*   - synchronous exception cause codes
package trap_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        WRITE,
        REDIRECT
    } trap_state_t;

    typedef enum logic [1:0] {
        TRAP_EXC,
        TRAP_IRQ,
        TRAP_MRET
    } trap_kind_t;

    typedef enum logic [1:0] {
        EXCPC_MTVEC = 2'd0,
        EXCPC_MEPC  = 2'd1
    } exc_pc_mux_t;

    localparam int unsigned MCAUSE_IRQ_BIT = 31;

    localparam logic [4:0] EXC_CAUSE_INSN_ADDR_MISALIGNED = 5'h00;
    localparam logic [4:0] EXC_CAUSE_INSN_ACCESS_FAULT    = 5'h01;
    localparam logic [4:0] EXC_CAUSE_ILLEGAL_INSN         = 5'h02;
    localparam logic [4:0] EXC_CAUSE_BREAKPOINT           = 5'h03;
    localparam logic [4:0] EXC_CAUSE_LOAD_ADDR_MISALIGNED = 5'h04;
    localparam logic [4:0] EXC_CAUSE_LOAD_ACCESS_FAULT    = 5'h05;
    localparam logic [4:0] EXC_CAUSE_STORE_ADDR_MISALIGNED= 5'h06;
    localparam logic [4:0] EXC_CAUSE_STORE_ACCESS_FAULT   = 5'h07;
    localparam logic [4:0] EXC_CAUSE_ECALL_MMODE          = 5'h0B;

endpackage

// File: rtl/trap_ctrl_pc_gen.sv
// trap_pc_gen: combinational trap target computation from mtvec.
//   i_mtvec    - current mtvec (base + mode bits)
//   i_kind     - latched trap kind
//   i_cause    - latched cause code
//   o_trap_pc  - fetch redirect target for trap entry
// Optional feature macro: TRAP_VECTORED_EN. When defined, vectored mode
// (mtvec[1:0] == 2'b01) offsets interrupt targets by cause*4; exceptions
// always use the base. When undefined, the mode bits are ignored.
module trap_pc_gen
    import trap_ctrl_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] i_mtvec,
    input  trap_kind_t      i_kind,
    input  logic [4:0]      i_cause,
    output logic [XLEN-1:0] o_trap_pc
);

    logic [XLEN-1:0] w_base;

    assign w_base = {i_mtvec[XLEN-1:2], 2'b00};

`ifdef TRAP_VECTORED_EN
    logic [XLEN-1:0] w_vec_off;

    assign w_vec_off = {{(XLEN-7){1'b0}}, i_cause, 2'b00};

    always_comb begin
        o_trap_pc = w_base;
        if (i_mtvec[1:0] == 2'b01 && i_kind == TRAP_IRQ) begin
            o_trap_pc = w_base + w_vec_off;
        end
    end
`else
    logic w_unused_vec;

    assign w_unused_vec = ^{i_mtvec[1:0], i_kind, i_cause};
    assign o_trap_pc    = w_base;
`endif

endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap entry / MRET sequencer for the 5-stage core.
// Accepts one source in IDLE (exception > enabled interrupt > MRET), flushes
// the pipeline, waits for drain (watchdog DRAIN_MAX), issues one cycle of CSR
// write strobes, then one cycle of fetch redirect.
// Inputs : clk_i, rst_i (async, active-high), exc_req_i/exc_cause_i/exc_tval_i,
//          epc_i, irq_i/irq_id_i, mret_i, mstatus_mie_i, mstatus_mpie_i,
//          mtvec_i, pipe_idle_i
// Outputs: flush_o, stall_o, busy_o, csr_we_o, csr_mstatus_we_o, mepc_o,
//          mcause_o, mtval_o, mstatus_mie_o, mstatus_mpie_o, pc_set_o,
//          pc_mux_o, trap_pc_o
// Optional feature macro: TRAP_VECTORED_EN (vectored interrupt targets,
// implemented in trap_pc_gen).
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned DRAIN_MAX = 15
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            exc_req_i,
    input  logic [4:0]      exc_cause_i,
    input  logic [XLEN-1:0] exc_tval_i,
    input  logic [XLEN-1:0] epc_i,
    input  logic            irq_i,
    input  logic [4:0]      irq_id_i,
    input  logic            mret_i,
    input  logic            mstatus_mie_i,
    input  logic            mstatus_mpie_i,
    input  logic [XLEN-1:0] mtvec_i,
    input  logic            pipe_idle_i,
    output logic            flush_o,
    output logic            stall_o,
    output logic            busy_o,
    output logic            csr_we_o,
    output logic            csr_mstatus_we_o,
    output logic [XLEN-1:0] mepc_o,
    output logic [XLEN-1:0] mcause_o,
    output logic [XLEN-1:0] mtval_o,
    output logic            mstatus_mie_o,
    output logic            mstatus_mpie_o,
    output logic            pc_set_o,
    output exc_pc_mux_t     pc_mux_o,
    output logic [XLEN-1:0] trap_pc_o
);

    // The counter is cleared on DRAIN entry and reaches DRAIN_MAX on the edge
    // that ends the DRAIN_MAX-th DRAIN cycle, so that edge is the exit point.
    localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_MAX - 1);

    trap_state_t      r_state;
    trap_state_t      w_state_nxt;
    trap_kind_t       r_kind;
    logic [4:0]       r_cause;
    logic [XLEN-1:0]  r_epc;
    logic [XLEN-1:0]  r_tval;
    logic [3:0]       r_drain_cnt;

    logic             w_accept;
    trap_kind_t       w_kind_sel;
    logic [4:0]       w_cause_sel;
    logic             w_drain_done;

    // Source arbitration in IDLE: exception, then enabled interrupt (not
    // coincident with MRET), then MRET.
    always_comb begin
        w_accept    = 1'b1;
        w_kind_sel  = TRAP_EXC;
        w_cause_sel = exc_cause_i;
        if (exc_req_i) begin
            w_kind_sel  = TRAP_EXC;
            w_cause_sel = exc_cause_i;
        end else if (irq_i && mstatus_mie_i && !mret_i) begin
            w_kind_sel  = TRAP_IRQ;
            w_cause_sel = irq_id_i;
        end else if (mret_i) begin
            w_kind_sel  = TRAP_MRET;
            w_cause_sel = '0;
        end else begin
            w_accept    = 1'b0;
        end
    end

    assign w_drain_done = pipe_idle_i || (r_drain_cnt >= DRAIN_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_kind      <= TRAP_EXC;
            r_cause     <= '0;
            r_epc       <= '0;
            r_tval      <= '0;
            r_drain_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && w_accept) begin
                r_kind      <= w_kind_sel;
                r_cause     <= w_cause_sel;
                r_epc       <= epc_i;
                r_tval      <= exc_tval_i;
                r_drain_cnt <= '0;
            end else if (r_state == DRAIN && r_drain_cnt != 4'hF) begin
                r_drain_cnt <= r_drain_cnt + 4'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        busy_o           = (r_state != IDLE);
        stall_o          = (r_state != IDLE);
        flush_o          = 1'b0;
        csr_we_o         = 1'b0;
        csr_mstatus_we_o = 1'b0;
        mepc_o           = '0;
        mcause_o         = '0;
        mtval_o          = '0;
        mstatus_mie_o    = 1'b0;
        mstatus_mpie_o   = 1'b0;
        pc_set_o         = 1'b0;
        pc_mux_o         = EXCPC_MTVEC;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    flush_o     = 1'b1;
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (w_drain_done) begin
                    w_state_nxt = WRITE;
                end
            end
            WRITE: begin
                csr_mstatus_we_o = 1'b1;
                if (r_kind == TRAP_MRET) begin
                    mstatus_mie_o  = mstatus_mpie_i;
                    mstatus_mpie_o = 1'b1;
                end else begin
                    csr_we_o                 = 1'b1;
                    mepc_o                   = r_epc;
                    mepc_o[0]                = 1'b0;
                    mcause_o[MCAUSE_IRQ_BIT] = (r_kind == TRAP_IRQ);
                    mcause_o[4:0]            = r_cause;
                    mtval_o                  = (r_kind == TRAP_EXC) ? r_tval : '0;
                    mstatus_mie_o            = 1'b0;
                    mstatus_mpie_o           = mstatus_mie_i;
                end
                w_state_nxt = REDIRECT;
            end
            REDIRECT: begin
                pc_set_o    = 1'b1;
                pc_mux_o    = (r_kind == TRAP_MRET) ? EXCPC_MEPC : EXCPC_MTVEC;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    trap_pc_gen #(
        .XLEN (XLEN)
    ) u_trap_pc_gen (
        .i_mtvec   (mtvec_i),
        .i_kind    (r_kind),
        .i_cause   (r_cause),
        .o_trap_pc (trap_pc_o)
    );

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: self-checking bench for trap_ctrl. Each transaction is
// checked against a timeline derived from the arbitration and drain rules:
// accept at offset 0, DRAIN exit at offset e = clamp(pipe_idle delay, 1, 15),
// WRITE at e+1, REDIRECT at e+2, IDLE again at e+3. Random request noise is
// applied while busy and must have no effect.
module tb_trap_ctrl;
    import trap_ctrl_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        exc_req_i;
    logic [4:0]  exc_cause_i;
    logic [31:0] exc_tval_i;
    logic [31:0] epc_i;
    logic        irq_i;
    logic [4:0]  irq_id_i;
    logic        mret_i;
    logic        mstatus_mie_i;
    logic        mstatus_mpie_i;
    logic [31:0] mtvec_i;
    logic        pipe_idle_i;
    logic        flush_o;
    logic        stall_o;
    logic        busy_o;
    logic        csr_we_o;
    logic        csr_mstatus_we_o;
    logic [31:0] mepc_o;
    logic [31:0] mcause_o;
    logic [31:0] mtval_o;
    logic        mstatus_mie_o;
    logic        mstatus_mpie_o;
    logic        pc_set_o;
    exc_pc_mux_t pc_mux_o;
    logic [31:0] trap_pc_o;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk_i = ~clk_i;

    trap_ctrl #(
        .XLEN      (32),
        .DRAIN_MAX (15)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .exc_req_i        (exc_req_i),
        .exc_cause_i      (exc_cause_i),
        .exc_tval_i       (exc_tval_i),
        .epc_i            (epc_i),
        .irq_i            (irq_i),
        .irq_id_i         (irq_id_i),
        .mret_i           (mret_i),
        .mstatus_mie_i    (mstatus_mie_i),
        .mstatus_mpie_i   (mstatus_mpie_i),
        .mtvec_i          (mtvec_i),
        .pipe_idle_i      (pipe_idle_i),
        .flush_o          (flush_o),
        .stall_o          (stall_o),
        .busy_o           (busy_o),
        .csr_we_o         (csr_we_o),
        .csr_mstatus_we_o (csr_mstatus_we_o),
        .mepc_o           (mepc_o),
        .mcause_o         (mcause_o),
        .mtval_o          (mtval_o),
        .mstatus_mie_o    (mstatus_mie_o),
        .mstatus_mpie_o   (mstatus_mpie_o),
        .pc_set_o         (pc_set_o),
        .pc_mux_o         (pc_mux_o),
        .trap_pc_o        (trap_pc_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_reqs();
        exc_req_i   = 1'b0;
        exc_cause_i = '0;
        exc_tval_i  = '0;
        epc_i       = '0;
        irq_i       = 1'b0;
        irq_id_i    = '0;
        mret_i      = 1'b0;
    endtask

    task automatic noise_reqs();
        exc_req_i   = 1'($urandom_range(0, 1));
        exc_cause_i = 5'($urandom);
        exc_tval_i  = $urandom;
        epc_i       = $urandom;
        irq_i       = 1'($urandom_range(0, 1));
        irq_id_i    = 5'($urandom);
        mret_i      = 1'($urandom_range(0, 1));
    endtask

    // One transaction. drain_d = first offset (from accept) at which pipe_idle_i is high.
    task automatic do_txn(input bit exc, input bit irq, input bit mret,
                          input logic [4:0] ecause, input logic [4:0] iid,
                          input logic [31:0] epc, input logic [31:0] tval,
                          input logic [31:0] mtvec, input bit mie, input bit mpie,
                          input int unsigned drain_d);
        int unsigned win;   // 0 none, 1 exception, 2 interrupt, 3 mret
        int unsigned e, w, r;
        logic [31:0] exp_cause, exp_pc;

        if (exc)                        win = 1;
        else if (irq && mie && !mret)   win = 2;
        else if (mret)                  win = 3;
        else                            win = 0;

        e = (drain_d < 1) ? 1 : ((drain_d > 15) ? 15 : drain_d);
        w = e + 1;
        r = e + 2;

        exp_cause = (win == 2) ? (32'h8000_0000 | 32'(iid)) : 32'(ecause);
        exp_pc    = mtvec & 32'hFFFF_FFFC;
`ifdef TRAP_VECTORED_EN
        if (mtvec[1:0] == 2'b01 && win == 2) exp_pc = exp_pc + 32'(iid) * 4;
`endif

        @(posedge clk_i); #1;
        exc_req_i      = exc;
        exc_cause_i    = ecause;
        exc_tval_i     = tval;
        epc_i          = epc;
        irq_i          = irq;
        irq_id_i       = iid;
        mret_i         = mret;
        mtvec_i        = mtvec;
        mstatus_mie_i  = mie;
        mstatus_mpie_i = mpie;
        pipe_idle_i    = (drain_d == 0);
        @(negedge clk_i);
        chk("flush_accept", 32'(flush_o), 32'(win != 0));
        chk("busy_accept",  32'(busy_o), 32'd0);

        if (win == 0) begin
            @(posedge clk_i); #1;
            clear_reqs();
            @(negedge clk_i);
            chk("busy_ignored",  32'(busy_o), 32'd0);
            chk("flush_ignored", 32'(flush_o), 32'd0);
            return;
        end

        for (int unsigned k = 1; k <= r + 1; k++) begin
            @(posedge clk_i); #1;
            pipe_idle_i = (k >= drain_d);
            if (k <= r && $urandom_range(0, 1) == 1) noise_reqs();
            else clear_reqs();
            @(negedge clk_i);
            chk("busy",       32'(busy_o), 32'(k <= r));
            chk("stall",      32'(stall_o), 32'(k <= r));
            chk("flush_busy", 32'(flush_o), 32'd0);
            chk("csr_we",     32'(csr_we_o), 32'(k == w && win != 3));
            chk("mstatus_we", 32'(csr_mstatus_we_o), 32'(k == w));
            chk("pc_set",     32'(pc_set_o), 32'(k == r));
            if (k == w) begin
                if (win == 3) begin
                    chk("mret_mie",  32'(mstatus_mie_o), 32'(mpie));
                    chk("mret_mpie", 32'(mstatus_mpie_o), 32'd1);
                end else begin
                    chk("mepc",      mepc_o, epc & 32'hFFFF_FFFE);
                    chk("mcause",    mcause_o, exp_cause);
                    chk("mtval",     mtval_o, (win == 1) ? tval : 32'd0);
                    chk("trap_mie",  32'(mstatus_mie_o), 32'd0);
                    chk("trap_mpie", 32'(mstatus_mpie_o), 32'(mie));
                end
            end
            if (k == r) begin
                chk("pc_mux", 32'(pc_mux_o), (win == 3) ? 32'(EXCPC_MEPC) : 32'(EXCPC_MTVEC));
                if (win != 3) chk("trap_pc", trap_pc_o, exp_pc);
            end
        end
    endtask

    task automatic reset_in_drain();
        @(posedge clk_i); #1;
        exc_req_i   = 1'b1;
        exc_cause_i = EXC_CAUSE_LOAD_ACCESS_FAULT;
        exc_tval_i  = 32'h1234_5678;
        epc_i       = 32'h0000_0400;
        pipe_idle_i = 1'b0;
        @(negedge clk_i);
        chk("rst_flush_accept", 32'(flush_o), 32'd1);
        @(posedge clk_i); #1;
        clear_reqs();
        @(negedge clk_i);
        chk("rst_in_drain_busy", 32'(busy_o), 32'd1);
        @(posedge clk_i); #2;
        rst_i = 1'b1;
        #1;
        chk("rst_async_busy", 32'(busy_o), 32'd0);
        chk("rst_async_we",   32'(csr_we_o | csr_mstatus_we_o | pc_set_o), 32'd0);
        @(posedge clk_i); #1;
        pipe_idle_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        for (int unsigned k = 0; k < 4; k++) begin
            @(negedge clk_i);
            chk("post_rst_busy",    32'(busy_o), 32'd0);
            chk("post_rst_strobes", 32'(csr_we_o | csr_mstatus_we_o | pc_set_o), 32'd0);
            @(posedge clk_i); #1;
        end
    endtask

    initial begin
        rst_i          = 1'b1;
        clear_reqs();
        mstatus_mie_i  = 1'b0;
        mstatus_mpie_i = 1'b0;
        mtvec_i        = '0;
        pipe_idle_i    = 1'b0;

        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("reset_busy",   32'(busy_o | stall_o | flush_o), 32'd0);
        chk("reset_strobe", 32'(csr_we_o | csr_mstatus_we_o | pc_set_o), 32'd0);
        chk("reset_csr",    mepc_o | mcause_o | mtval_o, 32'd0);
        chk("reset_mst",    32'(mstatus_mie_o | mstatus_mpie_o), 32'd0);
        chk("reset_pcmux",  32'(pc_mux_o), 32'(EXCPC_MTVEC));
        chk("reset_trappc", trap_pc_o, 32'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        // Illegal instruction
        do_txn(1, 0, 0, EXC_CAUSE_ILLEGAL_INSN, 5'd0, 32'h100, 32'hDEAD_BEEF,
               32'h800, 1, 0, 0);
        // MRET with MPIE=1, MIE=0
        do_txn(0, 0, 1, 5'd0, 5'd0, 32'h200, 32'h0, 32'h800, 0, 1, 0);
        // All three at once: exception wins, interrupt taken afterwards
        do_txn(1, 1, 1, EXC_CAUSE_ECALL_MMODE, 5'd7, 32'h300, 32'h0,
               32'h800, 1, 0, 1);
        do_txn(0, 1, 0, 5'd0, 5'd7, 32'h304, 32'h0, 32'h800, 1, 0, 2);
        // Interrupt masked: ignored
        do_txn(0, 1, 0, 5'd0, 5'd3, 32'h400, 32'h0, 32'h800, 0, 1, 0);
        // IRQ coincident with MRET: MRET wins
        do_txn(0, 1, 1, 5'd0, 5'd11, 32'h404, 32'h0, 32'h800, 1, 0, 0);
        // pipe_idle held low: watchdog forces WRITE
        do_txn(1, 0, 0, EXC_CAUSE_BREAKPOINT, 5'd0, 32'h501, 32'h42,
               32'h800, 1, 1, 40);
        // Vectored mtvec: interrupt and exception targets
        do_txn(0, 1, 0, 5'd0, 5'd7, 32'h600, 32'h0, 32'h801, 1, 0, 0);
        do_txn(1, 0, 0, EXC_CAUSE_ILLEGAL_INSN, 5'd0, 32'h604, 32'h0BAD,
               32'h801, 1, 0, 0);
        // Reset during DRAIN
        reset_in_drain();

        for (int unsigned t = 0; t < 60; t++) begin
            do_txn(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 2) == 0), 5'($urandom), 5'($urandom),
                   $urandom, $urandom, $urandom,
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 20));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Sequences machine-mode trap entry and MRET return for the 5-stage core.
- Arbitrates between three sources: synchronous exceptions, external interrupts and MRET.
- Flushes the pipeline, waits for drain, issues single-cycle CSR write strobes (mepc, mcause, mtval, mstatus), then redirects fetch via exc_pc_mux_t.
- Sits beside the CSR file; the controller/hazard unit consumes flush_o and stall_o.

Parameters:
- XLEN, 32, datapath/CSR width
- DRAIN_MAX, 15, max cycles spent in DRAIN before forcing WRITE (watchdog)

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  asynchronous, active-high reset
- exc_req_i  in  1  synchronous exception from MEM stage
- exc_cause_i  in  5  EXC_CAUSE_* code
- exc_tval_i  in  XLEN  faulting address or instruction
- epc_i  in  XLEN  PC of excepting instruction, or of next unretired instruction for interrupts
- irq_i  in  1  any enabled interrupt pending (mip & mie != 0)
- irq_id_i  in  5  interrupt cause code
- mret_i  in  1  MRET reached MEM stage
- mstatus_mie_i  in  1  current mstatus.MIE
- mstatus_mpie_i  in  1  current mstatus.MPIE
- mtvec_i  in  XLEN  current mtvec
- pipe_idle_i  in  1  no in-flight instruction past IF
- flush_o  out  1  one-cycle pipeline flush
- stall_o  out  1  hold IF/ID while busy
- busy_o  out  1  FSM not IDLE
- csr_we_o  out  1  write strobe for mepc/mcause/mtval (trap only)
- csr_mstatus_we_o  out  1  mstatus write strobe
- mepc_o  out  XLEN  value for mepc
- mcause_o  out  XLEN  value for mcause
- mtval_o  out  XLEN  value for mtval
- mstatus_mie_o  out  1  new MIE
- mstatus_mpie_o  out  1  new MPIE
- pc_set_o  out  1  one-cycle fetch redirect
- pc_mux_o  out  exc_pc_mux_t  EXCPC_MTVEC / EXCPC_MEPC
- trap_pc_o  out  XLEN  redirect target when pc_mux_o = EXCPC_MTVEC

Behaviour:
- Reset: state IDLE; all outputs 0; pc_mux_o = EXCPC_MTVEC; internal latches cleared. Reset mid-sequence aborts with no strobes issued.
- States: IDLE, DRAIN, WRITE, REDIRECT.
- IDLE priority, same cycle:
  - exc_req_i first.
  - then irq_i && mstatus_mie_i && !mret_i.
  - then mret_i.
- Accepting a source:
  - Latch kind (EXC/IRQ/MRET), cause, epc_i, tval.
  - Assert flush_o for exactly that cycle; go to DRAIN.
- busy_o = stall_o = (state != IDLE). All requests are ignored while busy.
- DRAIN: leave for WRITE on pipe_idle_i, or once the drain counter reaches DRAIN_MAX.
- WRITE (exactly one cycle):
  - Trap:
    - csr_we_o = 1, csr_mstatus_we_o = 1.
    - mepc_o = {latched epc[XLEN-1:1], 1'b0}.
    - mcause_o = {is_irq, 26'b0, cause}.
    - mtval_o = tval for exceptions, 0 for interrupts.
    - mstatus_mie_o = 0; mstatus_mpie_o = mstatus_mie_i.
  - MRET:
    - csr_we_o = 0, csr_mstatus_we_o = 1.
    - mstatus_mie_o = mstatus_mpie_i; mstatus_mpie_o = 1.
- REDIRECT (exactly one cycle):
  - pc_set_o = 1.
  - pc_mux_o = EXCPC_MEPC for MRET, else EXCPC_MTVEC.
  - Next state IDLE.
- Latency: trap entry to pc_set_o is 3 cycles minimum (accept → DRAIN → WRITE → REDIRECT, with pipe_idle_i already high).
- trap_pc_o = {mtvec_i[XLEN-1:2], 2'b00} (base mode).
- An exception arriving in the same cycle as pc_set_o is ignored (busy); it cannot occur anyway because the pipeline was flushed.
- Drain counter: 4 bits, saturating, cleared on entering DRAIN.

Optional Feature:
- TRAP_VECTORED_EN defined: when mtvec_i[1:0] == 2'b01 and the latched kind is IRQ, trap_pc_o = base + (cause << 2). Exceptions always use base.
- TRAP_VECTORED_EN undefined: mtvec mode bits are ignored; trap_pc_o is always base.

Decomposition:
- Add to core_pkg:
  - trap_state_t enum (IDLE, DRAIN, WRITE, REDIRECT).
  - trap_kind_t enum (TRAP_EXC, TRAP_IRQ, TRAP_MRET).
  - localparam MCAUSE_IRQ_BIT = 31.
  - Reuse exc_pc_mux_t and EXC_CAUSE_*.
- One sub-module: trap_pc_gen, a combinational mtvec base/vector computation holding the TRAP_VECTORED_EN logic.

Test Plan:
- Illegal instruction: exc_req_i, cause 5'h02, epc 0x100, tval 0xDEADBEEF, pipe_idle_i = 1, mtvec 0x800, MIE = 1.
  → flush_o in the accept cycle; WRITE writes mepc 0x100, mcause 0x2, mtval 0xDEADBEEF, MIE 0, MPIE 1; pc_set_o 3 cycles after accept, target 0x800.
- MRET with MPIE = 1, MIE = 0.
  → csr_we_o stays 0; mstatus write MIE 1, MPIE 1; pc_mux_o = EXCPC_MEPC.
- Same cycle exc_req_i (cause 5'h0B), irq_i (id 7) and mret_i.
  → exception wins; mcause 0xB; the interrupt is taken only after IDLE, giving mcause 0x80000007.
- irq_i with MIE = 0.
  → no action, busy_o stays 0.
- pipe_idle_i held low.
  → WRITE is forced after 15 DRAIN cycles.
- rst_i asserted in DRAIN.
  → immediate IDLE, no strobes.
- With TRAP_VECTORED_EN, mtvec 0x801, irq id 7.
  → trap_pc_o 0x81C.
- With TRAP_VECTORED_EN, same mtvec, exception.
  → trap_pc_o 0x800.
